// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder controller.
// Contents: nibble width, controller state encoding, index-width helper.
package adder_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of a counter addressing n nibbles; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
   endfunction

endpackage

// File: rtl/fulladder_4bit.sv
// Purely combinational 4-bit ripple adder slice.
// Ports: sum/carry_out results; carry_in, a, b operands.
module fulladder_4bit (
   output logic [3:0] sum,
   output logic       carry_out,
   input  logic       carry_in,
   input  logic [3:0] a,
   input  logic [3:0] b
);

   assign {carry_out, sum} = 5'(a) + 5'(b) + 5'(carry_in);

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Time-shares one fulladder_4bit slice to add/subtract W-bit operands,
// one nibble per clock, LSB nibble first.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            begin an operation (honoured only in IDLE)
//   sub, cin         0 = a+b+cin, 1 = a-b-cin (cin acts as borrow-in)
//   a_in, b_in       W-bit operands, latched on the accepted start
//   busy             high while nibbles are being processed
//   done             one-cycle pulse when result/cout/ovf are valid
//   result, cout, ovf  sum/difference, carry (1 = no borrow), signed overflow
module nibble_serial_adder_ctrl
   import adder_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         sub,
   input  logic                         cin,
   input  logic [NIBBLE_W*NIBBLES-1:0]  a_in,
   input  logic [NIBBLE_W*NIBBLES-1:0]  b_in,
   output logic                         busy,
   output logic                         done,
   output logic [NIBBLE_W*NIBBLES-1:0]  result,
   output logic                         cout,
   output logic                         ovf
);

   localparam int unsigned W     = NIBBLE_W * NIBBLES;
   localparam int unsigned IDX_W = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_e             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       result_q;
   logic [W-1:0]       result_d;
   logic               cout_q;
   logic               ovf_q;
   logic               busy_q;
   logic               done_q;

   logic [31:0]         nib_sh;
   logic [NIBBLE_W-1:0] slice_a;
   logic [NIBBLE_W-1:0] slice_b;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;
   logic [W-1:0]        nib_mask;

   // Select the current nibble of each operand; shifting avoids
   // out-of-range part-selects when NIBBLES is 1.
   assign nib_sh   = 32'(NIBBLE_W) * 32'(idx_q);
   assign slice_a  = NIBBLE_W'(a_q >> nib_sh);
   assign slice_b  = NIBBLE_W'(b_q >> nib_sh);
   assign nib_mask = W'({NIBBLE_W{1'b1}}) << nib_sh;
   assign result_d = (result_q & ~nib_mask) | (W'(slice_sum) << nib_sh);

   fulladder_4bit u_slice (
      .sum       (slice_sum),
      .carry_out (slice_cout),
      .carry_in  (carry_q),
      .a         (slice_a),
      .b         (slice_b)
   );

   // Sequencer: latch operands, walk the nibbles, pulse done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  // Subtraction is a + ~b + ~borrow.
                  a_q      <= a_in;
                  b_q      <= sub ? ~b_in : b_in;
                  carry_q  <= cin ^ sub;
                  result_q <= '0;
                  idx_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               result_q <= result_d;
               carry_q  <= slice_cout;
               idx_q    <= idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  cout_q  <= slice_cout;
                  ovf_q   <= (a_q[W-1] == b_q[W-1]) &&
                             (slice_sum[NIBBLE_W-1] != a_q[W-1]);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: 4-nibble and 1-nibble controllers, directed vectors.
module tb_nibble_serial_adder_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
   logic [15:0] a4 = '0, b4 = '0;
   logic        busy4, done4, cout4, ovf4;
   logic [15:0] res4;

   logic        start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
   logic [3:0]  a1 = '0, b1 = '0;
   logic        busy1, done1, cout1, ovf1;
   logic [3:0]  res1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub4), .cin(cin4),
      .a_in(a4), .b_in(b4), .busy(busy4), .done(done4),
      .result(res4), .cout(cout4), .ovf(ovf4)
   );

   nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub1), .cin(cin1),
      .a_in(a1), .b_in(b1), .busy(busy1), .done(done1),
      .result(res1), .cout(cout1), .ovf(ovf1)
   );

   typedef struct {
      logic        sub;
      logic        cin;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        cout;
      logic        ovf;
   } vec_t;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit one, input logic st, input logic s, input logic c,
                        input logic [15:0] a, input logic [15:0] b);
      if (one) begin
         start1 = st; sub1 = s; cin1 = c; a1 = a[3:0]; b1 = b[3:0];
      end else begin
         start4 = st; sub4 = s; cin4 = c; a4 = a; b4 = b;
      end
   endtask

   // One operation: start at edge k, then watch cycles k+1..k+n+4.
   task automatic run_op(input string tag, input bit one, input vec_t v, input bit disturb);
      int n;
      int busy_in, busy_out, done_cnt, done_at;
      logic [15:0] r_at, r_now;
      logic c_at, o_at, b_s, d_s;
      n = one ? 1 : 4;
      busy_in = 0; busy_out = 0; done_cnt = 0; done_at = 0;
      r_at = '0; c_at = 1'b0; o_at = 1'b0;
      @(negedge clk);
      drive(one, 1'b1, v.sub, v.cin, v.a, v.b);
      for (int j = 1; j <= n + 4; j++) begin
         @(negedge clk);
         b_s   = one ? busy1 : busy4;
         d_s   = one ? done1 : done4;
         r_now = one ? 16'(res1) : res4;
         if (b_s) begin
            if (j <= n) busy_in++;
            else        busy_out++;
         end
         if (d_s) begin
            done_cnt++;
            done_at = j;
            r_at = r_now;
            c_at = one ? cout1 : cout4;
            o_at = one ? ovf1 : ovf4;
         end
         // Disturbance: inverted operands and a held start through RUN and DONE.
         if (disturb && j <= n + 1)
            drive(one, 1'b1, ~v.sub, ~v.cin, ~v.a, v.b ^ 16'h5a5a);
         else
            drive(one, 1'b0, v.sub, v.cin, v.a, v.b);
      end
      check({tag, " busy_cycles"}, 16'(busy_in), 16'(n));
      check({tag, " busy_extra"}, 16'(busy_out), 16'd0);
      check({tag, " done_count"}, 16'(done_cnt), 16'd1);
      check({tag, " done_cycle"}, 16'(done_at), 16'(n + 1));
      check({tag, " result"}, r_at, v.res);
      check({tag, " cout"}, 16'(c_at), 16'(v.cout));
      check({tag, " ovf"}, 16'(o_at), 16'(v.ovf));
      check({tag, " result_held"}, r_now, v.res);
   endtask

   vec_t v4[8];
   vec_t v1[3];
   vec_t vx;

   initial begin
      //         sub   cin   a         b         result    cout  ovf
      v4[0] = '{1'b0, 1'b0, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0};
      v4[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
      v4[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
      v4[3] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
      v4[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
      v4[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
      v4[6] = '{1'b1, 1'b1, 16'h0010, 16'h0001, 16'h000E, 1'b1, 1'b0};
      v4[7] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

      v1[0] = '{1'b0, 1'b0, 16'h000F, 16'h0001, 16'h0000, 1'b1, 1'b0};
      v1[1] = '{1'b0, 1'b0, 16'h0007, 16'h0001, 16'h0008, 1'b0, 1'b1};
      v1[2] = '{1'b1, 1'b0, 16'h0003, 16'h0005, 16'h000E, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst busy4", 16'(busy4), 16'd0);
      check("rst done4", 16'(done4), 16'd0);
      check("rst result4", res4, 16'h0000);
      check("rst cout_ovf4", 16'({cout4, ovf4}), 16'd0);
      check("rst result1", 16'(res1), 16'd0);
      rst = 1'b0;

      foreach (v4[i]) run_op($sformatf("n4_vec%0d", i), 1'b0, v4[i], 1'b0);

      // Start and operand changes during RUN/DONE must be ignored.
      vx = '{1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0};
      run_op("n4_ignore_start", 1'b0, vx, 1'b1);

      // Leave cout/ovf set so the reset clearing them is observable.
      run_op("n4_pre_abort", 1'b0, v4[7], 1'b0);

      // Abort during the second RUN cycle.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
      @(negedge clk);
      check("abort busy_before", 16'(busy4), 16'd1);
      rst = 1'b1;
      #1;
      check("abort busy", 16'(busy4), 16'd0);
      check("abort done", 16'(done4), 16'd0);
      check("abort result", res4, 16'h0000);
      check("abort cout", 16'(cout4), 16'd0);
      check("abort ovf", 16'(ovf4), 16'd0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("abort no_done", 16'(done4), 16'd0);
      end
      rst = 1'b0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check("post_abort idle_done", 16'(done4), 16'd0);
      end
      vx = '{1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
      run_op("n4_after_reset", 1'b0, vx, 1'b0);

      foreach (v1[i]) run_op($sformatf("n1_vec%0d", i), 1'b1, v1[i], 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
